// File: rtl/pwm_pkg.sv
// Shared register map, control/status bit positions and counter direction
// for the multi-channel Avalon PWM block.
package pwm_pkg;

    localparam logic [3:0] ADDR_ARR    = 4'd0;
    localparam logic [3:0] ADDR_CTRL   = 4'd1;
    localparam logic [3:0] ADDR_POL    = 4'd2;
    localparam logic [3:0] ADDR_STATUS = 4'd3;
    localparam logic [3:0] ADDR_CCR0   = 4'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CENTER = 1;
    localparam int CTRL_IE     = 2;
    localparam int STATUS_PEF  = 0;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_cmp_chan.sv
// One PWM channel: double-buffered compare register, comparator against the
// shared counter, polarity inversion and registered output.
module pwm_cmp_chan #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wdata_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] ccr_o,
    output logic             pwm_o
);

    logic [CNT_W-1:0] ccr_sh_q;
    logic [CNT_W-1:0] ccr_act_q;
    logic             pwm_q;
    logic             pwm_d;

    // Compare against the current count; the output lags the counter by one cycle.
    assign pwm_d = en_i ? ((cnt_i < ccr_act_q) ^ pol_i) : pol_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ccr_sh_q  <= '0;
            ccr_act_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            if (wr_i)   ccr_sh_q  <= wdata_i;
            if (load_i) ccr_act_q <= ccr_sh_q;
            pwm_q <= pwm_d;
        end
    end

    assign ccr_o = ccr_sh_q;
    assign pwm_o = pwm_q;

endmodule

// File: rtl/av_pwm_mc.sv
// Avalon-MM slave PWM timer: shared edge/center-aligned counter, control and
// status registers, bus decode, and NUM_CH compare channels.
module av_pwm_mc
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              as_chipselect,
    input  logic [3:0]        as_address,
    input  logic              as_write,
    input  logic [31:0]       as_writedata,
    output logic [31:0]       as_readdata,
    output logic [NUM_CH-1:0] o_pwm,
    output logic              o_irq
);

    logic [CNT_W-1:0]  arr_sh_q, arr_act_q;
    logic              en_q, center_q, ie_q, center_act_q;
    logic [NUM_CH-1:0] pol_q;
    logic              pef_q, pef_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dir_e              dir_q, dir_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  ccr_sh [NUM_CH];
    logic              wr, upd, load;

    assign wr = as_chipselect & as_write;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en_q) begin
            cnt_d = '0;
        end else if (!center_act_q) begin
            cnt_d = (cnt_q >= arr_act_q) ? '0 : cnt_q + 1'b1;
        end else if (dir_q == UP) begin
            if (cnt_q >= arr_act_q) begin
                cnt_d = (arr_act_q == '0) ? '0 : arr_act_q - 1'b1;
                dir_d = DOWN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        if (cnt_d == '0) dir_d = UP;
    end

    // A new period starts whenever the next count is zero.
    assign upd   = en_q & (cnt_d == '0);
    assign load  = ~en_q | upd;
    assign pef_d = upd | (pef_q & ~(wr && as_address == ADDR_STATUS && as_writedata[STATUS_PEF]));

    always_comb begin
        rdata_d = '0;
        case (as_address)
            ADDR_ARR:    rdata_d = 32'(arr_sh_q);
            ADDR_CTRL: begin
                rdata_d[CTRL_EN]     = en_q;
                rdata_d[CTRL_CENTER] = center_q;
                rdata_d[CTRL_IE]     = ie_q;
            end
            ADDR_POL:    rdata_d = 32'(pol_q);
            ADDR_STATUS: rdata_d[STATUS_PEF] = pef_q;
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (as_address == ADDR_CCR0 + 4'(n)) rdata_d = 32'(ccr_sh[n]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arr_sh_q     <= '0;
            arr_act_q    <= '0;
            en_q         <= 1'b0;
            center_q     <= 1'b0;
            ie_q         <= 1'b0;
            center_act_q <= 1'b0;
            pol_q        <= '0;
            pef_q        <= 1'b0;
            cnt_q        <= '0;
            dir_q        <= UP;
            rdata_q      <= '0;
        end else begin
            if (wr) begin
                case (as_address)
                    ADDR_ARR:  arr_sh_q <= as_writedata[CNT_W-1:0];
                    ADDR_CTRL: begin
                        en_q     <= as_writedata[CTRL_EN];
                        center_q <= as_writedata[CTRL_CENTER];
                        ie_q     <= as_writedata[CTRL_IE];
                    end
                    ADDR_POL:  pol_q <= as_writedata[NUM_CH-1:0];
                    default:   ;
                endcase
            end
            if (load) begin
                arr_act_q    <= arr_sh_q;
                center_act_q <= center_q;
            end
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            pef_q <= pef_d;
            if (as_chipselect) rdata_q <= rdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [3:0] CH_ADDR = ADDR_CCR0 + 4'(g);
        pwm_cmp_chan #(.CNT_W(CNT_W)) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_i    (wr && as_address == CH_ADDR),
            .wdata_i (as_writedata[CNT_W-1:0]),
            .load_i  (load),
            .en_i    (en_q),
            .pol_i   (pol_q[g]),
            .cnt_i   (cnt_q),
            .ccr_o   (ccr_sh[g]),
            .pwm_o   (o_pwm[g])
        );
    end

    assign as_readdata = rdata_q;
    assign o_irq       = pef_q & ie_q;

endmodule

// File: tb/tb_av_pwm_mc.sv
// Self-checking bench for av_pwm_mc: read scoreboard plus analytic PWM
// waveform expectations for edge, center, shadow, boundary and reset cases.
module tb_av_pwm_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              reset_n;
    logic              as_chipselect;
    logic [3:0]        as_address;
    logic              as_write;
    logic [31:0]       as_writedata;
    logic [31:0]       as_readdata;
    logic [NUM_CH-1:0] o_pwm;
    logic              o_irq;

    av_pwm_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .as_chipselect (as_chipselect),
        .as_address    (as_address),
        .as_write      (as_write),
        .as_writedata  (as_writedata),
        .as_readdata   (as_readdata),
        .o_pwm         (o_pwm),
        .o_irq         (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] expv;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          t0       = 0;
    int          ccr_m [NUM_CH];
    logic [3:0]  pol_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Read data appears on the edge that samples the request; pop and compare then.
    always @(posedge clk) begin
        rd_exp_t e;
        if (reset_n && as_chipselect && !as_write) begin
            #1;
            if (rd_q.size() == 0) begin
                check("rd_underflow", 32'(rd_q.size()), 32'd1);
            end else begin
                e = rd_q.pop_front();
                check(e.tag, as_readdata, e.expv);
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        as_chipselect = 1'b1;
        as_write      = 1'b1;
        as_address    = a;
        as_writedata  = d;
        @(negedge clk);
        as_chipselect = 1'b0;
        as_write      = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] expv, input string tag);
        rd_exp_t e;
        e.tag  = tag;
        e.expv = expv;
        rd_q.push_back(e);
        as_chipselect = 1'b1;
        as_write      = 1'b0;
        as_address    = a;
        @(negedge clk);
        as_chipselect = 1'b0;
    endtask

    task automatic wait_until(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic start_run();
        bus_write(4'd1, 32'(pwm_pkg::CTRL_EN) == 0 ? 32'h0 : 32'h0);
    endtask

    // Output at sample k reflects the count one edge earlier; sample 0 is pre-enable.
    function automatic logic exp_pwm(input int k, input bit center, input int arr,
                                     input int ccr, input logic pol);
        int per, s, c;
        if (k < 1) return pol;
        per = center ? 2 * arr : arr + 1;
        s   = (k - 1) % per;
        c   = (center && s > arr) ? 2 * arr - s : s;
        return logic'(c < ccr) ^ pol;
    endfunction

    task automatic capture(input int n, input bit center, input int arr,
                           input bit shadow, input string tag);
        logic [3:0] ev;
        int k, c0, p;
        for (int i = 0; i < n; i++) begin
            k  = cyc - t0;
            c0 = ccr_m[0];
            if (shadow) begin
                p  = (k - 1) / (arr + 1);
                c0 = (p < 5) ? 3 : (p == 5) ? 5 : 8;
            end
            for (int ch = 0; ch < NUM_CH; ch++)
                ev[ch] = exp_pwm(k, center, arr, (ch == 0) ? c0 : ccr_m[ch], pol_m[ch]);
            check(tag, 32'(o_pwm), 32'(ev));
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        as_chipselect = 1'b0;
        as_write      = 1'b0;
        as_address    = 4'd0;
        as_writedata  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(o_pwm), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_rdata", as_readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        bus_read(4'd0, 32'd0, "rst_arr");
        bus_read(4'd1, 32'd0, "rst_ctrl");
        bus_read(4'd2, 32'd0, "rst_pol");
        bus_read(4'd3, 32'd0, "rst_status");
        bus_read(4'd4, 32'd0, "rst_ccr0");
        bus_read(4'd7, 32'd0, "rst_ccr3");

        // Configuration and register access rules.
        bus_write(4'd0, 32'd9);
        bus_write(4'd4, 32'd3);
        bus_write(4'd5, 32'd0);
        bus_write(4'd6, 32'd0);
        bus_write(4'd7, 32'd20);
        bus_write(4'd2, 32'hFFFF_FFFF);
        bus_read(4'd2, 32'h0000_000F, "pol_trunc");
        bus_write(4'd2, 32'd0);
        bus_write(4'd8, 32'hDEAD_BEEF);
        bus_read(4'd8, 32'd0, "unmapped");
        bus_read(4'd0, 32'd9, "arr_rb");
        bus_read(4'd7, 32'd20, "ccr3_rb");
        bus_write(4'd1, 32'hFFFF_FFF8);
        bus_read(4'd1, 32'd0, "ctrl_drop");

        // Edge mode, ARR=9: ch0 duty 3, ch1/ch2 0%, ch3 100%.
        ccr_m = '{3, 0, 0, 20};
        pol_m = 4'h0;
        bus_write(4'd1, 32'd5);
        t0 = cyc;
        capture(30, 1'b0, 9, 1'b0, "edge");
        check("irq_set", 32'(o_irq), 32'd1);
        bus_write(4'd3, 32'd1);
        check("irq_clr", 32'(o_irq), 32'd0);
        bus_read(4'd3, 32'd0, "pef_clr");
        wait_until(38);
        bus_read(4'd3, 32'd0, "pef_mid");
        bus_write(4'd3, 32'd1);
        check("irq_setwins", 32'(o_irq), 32'd1);
        bus_read(4'd3, 32'd1, "pef_setwins");
        bus_write(4'd3, 32'd1);
        check("irq_midclr", 32'(o_irq), 32'd0);

        // Shadow CCR updates land only at the period boundary.
        wait_until(44);
        bus_write(4'd4, 32'd5);
        bus_read(4'd4, 32'd5, "ccr0_shadow_rb");
        fork
            capture(40, 1'b0, 9, 1'b1, "shadow");
            begin
                wait_until(52);
                bus_write(4'd4, 32'd8);
            end
        join
        ccr_m[0] = 8;

        // Disable forces outputs to polarity one cycle after EN drops.
        bus_write(4'd2, 32'd5);
        bus_write(4'd1, 32'd4);
        @(negedge clk);
        check("dis_pol", 32'(o_pwm), 32'h5);

        // Center mode, ARR=4: period 8, ch1 high for cnt in {0,1}.
        bus_write(4'd2, 32'd0);
        bus_write(4'd0, 32'd4);
        bus_write(4'd5, 32'd2);
        bus_write(4'd1, 32'd2);
        bus_write(4'd3, 32'd1);
        ccr_m = '{8, 2, 0, 20};
        pol_m = 4'h0;
        bus_write(4'd1, 32'd3);
        t0 = cyc;
        capture(24, 1'b1, 4, 1'b0, "center");
        bus_read(4'd3, 32'd1, "ctr_pef");
        bus_write(4'd3, 32'd1);
        wait_until(31);
        bus_read(4'd3, 32'd0, "ctr_pef_mid");
        bus_read(4'd3, 32'd1, "ctr_pef_upd");

        // Boundaries with inverted polarity: ch1 CCR=0 -> 1, ch2 CCR=20 -> 0.
        bus_write(4'd1, 32'd0);
        bus_write(4'd0, 32'd9);
        bus_write(4'd5, 32'd0);
        bus_write(4'd6, 32'd20);
        bus_write(4'd2, 32'd6);
        bus_write(4'd3, 32'd1);
        ccr_m = '{8, 0, 20, 20};
        pol_m = 4'h6;
        bus_write(4'd1, 32'd5);
        t0 = cyc;
        capture(12, 1'b0, 9, 1'b0, "bound");
        check("irq_pre_rst", 32'(o_irq), 32'd1);

        // Reset mid-period clears everything immediately.
        reset_n = 1'b0;
        #1;
        check("midrst_pwm", 32'(o_pwm), 32'd0);
        check("midrst_irq", 32'(o_irq), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(4'd0, 32'd0, "midrst_arr");
        bus_read(4'd1, 32'd0, "midrst_ctrl");
        bus_read(4'd2, 32'd0, "midrst_pol");
        bus_read(4'd3, 32'd0, "midrst_status");
        bus_read(4'd6, 32'd0, "midrst_ccr2");
        check("midrst_pwm_after", 32'(o_pwm), 32'd0);
        check("sb_empty", 32'(rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/av_pwm_mc.md
AV_PWM_MC -- requirements
Module: av_pwm_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of PWM channels (legal 1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/compare width (legal 8..32).
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port as_chipselect, input, 1, slave select.
REQ-006 SHALL have port as_address, input, 4, word address.
REQ-007 SHALL have port as_write, input, 1, write strobe.
REQ-008 SHALL have port as_writedata, input, 32, write data.
REQ-009 SHALL have port as_readdata, output, 32, registered read data.
REQ-010 SHALL have port o_pwm, output, NUM_CH, registered PWM outputs.
REQ-011 SHALL have port o_irq, output, 1, period interrupt, level.

Function
REQ-012 Register map SHALL be:
- 0: ARR shadow (CNT_W bits).
- 1: CTRL, with bit0 EN, bit1 CENTER, bit2 IE.
- 2: POL (NUM_CH bits).
- 3: STATUS, with bit0 PEF, write-1-to-clear.
- 4+n: CCR[n] shadow for n < NUM_CH.
REQ-013 Writes SHALL take effect when as_chipselect and as_write are both high. Writes to unmapped addresses SHALL be ignored. Unused writedata bits SHALL be dropped.
REQ-014 Reads SHALL have 1-cycle latency; as_readdata updates on the edge after as_chipselect is sampled.
- ARR and CCR reads SHALL return shadow values, zero-extended.
- Unmapped addresses SHALL read 0.
- When as_chipselect is low, as_readdata SHALL hold its value.
REQ-015 ARR and CCR SHALL be double-buffered: bus writes go to the shadow registers; the active registers load from the shadows only on an update event, or on every cycle while EN=0.
REQ-016 The update event SHALL be the cycle whose next count value starts a new period. With active ARR=0, the update event SHALL occur every cycle.
REQ-017 Edge mode (CENTER=0): the counter SHALL count 0..ARR_act and wrap to 0. The update event SHALL be the cycle with cnt==ARR_act. Period SHALL be ARR_act+1 cycles.
REQ-018 Center mode (CENTER=1): the counter SHALL count 0 up to ARR_act, then down to 1, then 0. Period SHALL be 2*ARR_act cycles. The update event SHALL be the cycle whose next count is 0.
REQ-019 With EN=0, the counter SHALL be held at 0, direction SHALL be up, and o_pwm[n] SHALL equal POL[n].
REQ-020 With EN=1, o_pwm[n] SHALL be registered as (cnt < CCR_act[n]) XOR POL[n], one cycle after the counter value.
- CCR=0 SHALL give 0% duty.
- CCR > ARR_act SHALL give 100% duty.
REQ-021 An EN 0→1 write SHALL start counting from 0 on the next cycle using the already-loaded active values. An EN 1→0 write SHALL force cnt=0 and o_pwm=POL on the following cycle.
REQ-022 A CENTER change while EN=1 SHALL take effect at the next update event.
REQ-023 PEF SHALL set on every update event while EN=1. A simultaneous set and write-1-clear SHALL leave PEF set.
REQ-024 o_irq SHALL be combinational PEF AND IE.
REQ-025 Counter arithmetic SHALL be CNT_W-bit unsigned with no overflow; ARR_act = 2^CNT_W−1 is legal.

Reset
REQ-026 Reset SHALL clear to 0: all shadow and active registers, CTRL, POL, PEF, the counter, direction (up), as_readdata, and o_pwm.
REQ-027 Reset mid-period SHALL abort the period with no glitch beyond the reset itself. o_irq SHALL be 0 during reset.

Structure
REQ-028 Package pwm_pkg SHALL hold the register address constants, the CTRL/STATUS bit positions, and a direction enum (UP, DOWN).
REQ-029 Sub-module pwm_cmp_chan SHALL hold one channel: CCR shadow, CCR active, comparator, polarity, and output register. It SHALL be instantiated NUM_CH times by generate. The counter, CTRL and bus decode SHALL be in the top level.

Verification
REQ-030 Edge mode: ARR=9, CCR0=3, POL=0, EN=1 → o_pwm[0] high 3 cycles, low 7 cycles, period 10; PEF sets once per period.
REQ-031 Center mode: ARR=4, CCR1=2, CENTER=1, EN=1 → period 8; o_pwm[1] high only for cnt∈{0,1}; high pulses symmetric about the valley.
REQ-032 Shadow update: while running with ARR=9, write CCR0=5 at cnt=4 → current period keeps duty 3; the next period has duty 5. readback CCR0=5 immediately.
REQ-033 Boundaries:
- CCR2=0 → o_pwm[2] constantly 0.
- CCR2=20 with ARR=9 → o_pwm[2] constantly 1.
- POL[2]=1 inverts both cases.
REQ-034 Interrupt: IE=1, PEF set → o_irq=1. Write STATUS=1 on the update-event cycle → PEF stays 1. Write STATUS=1 mid-period → o_irq=0.
REQ-035 Reset and disable:
- Assert reset_n mid-period → all reads return 0 and o_pwm=0.
- EN 1→0 with POL=0x5 → o_pwm=0x5 one cycle later.
